// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones over a window of valid samples
// and presents the result on a valid/ready handshake. Optional SC_BIPOLAR_EN adds value_bp.
module sc_stream_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] len,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SC_BIPOLAR_EN
    ,
    output logic signed [WIDTH:0] value_bp
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] len_r;
    logic [WIDTH-1:0] samples_r;
    logic [WIDTH-1:0] ones_r;
    logic             busy_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] ones_next_s;
    logic             last_sample_s;

    // Running ones total and detection of the sample that closes the window
    always_comb begin
        ones_next_s   = ones_r + WIDTH'(bit_in);
        last_sample_s = (state_r == ACCUM) && bit_valid && ((samples_r + WIDTH'(1)) == len_r);
    end

    // Conversion FSM; busy and out_valid are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            len_r       <= '0;
            samples_r   <= '0;
            ones_r      <= '0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r     <= len;
                        samples_r <= '0;
                        ones_r    <= '0;
                        busy_r    <= 1'b1;
                        if (len == '0) begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bit_valid) begin
                        samples_r <= samples_r + WIDTH'(1);
                        ones_r    <= ones_next_s;
                        if (last_sample_s) begin
                            state_r     <= HOLD;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // ones_r is left untouched so count survives the handshake
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign count     = ones_r;

`ifdef SC_BIPOLAR_EN
    logic signed [WIDTH:0] value_r;

    // Bipolar estimate 2*ones - len; the true result always fits in WIDTH+1 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= '0;
        end else if ((state_r == IDLE) && start) begin
            value_r <= '0;
        end else if (last_sample_s) begin
            value_r <= {ones_next_s, 1'b0} - {1'b0, len_r};
        end else begin
            value_r <= value_r;
        end
    end

    assign value_bp = value_r;
`endif

endmodule

// File: tb/tb_sc_stream_counter.sv
// Self-checking bench for sc_stream_counter: directed and random conversions
// checked against a window-counting reference model.
module tb_sc_stream_counter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] len;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic             out_valid;
    logic             out_ready;
`ifdef SC_BIPOLAR_EN
    logic signed [WIDTH:0] value_bp;
`endif

    int errors = 0;
    int checks = 0;

    sc_stream_counter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SC_BIPOLAR_EN
        ,
        .value_bp  (value_bp)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full conversion. mode 0: all ones, 1: alternating bits,
    // 2: random bits with random gaps, 3: valid pattern 1001101 with ones.
    // exp_lat: expected cycles from start to out_valid (0 = not checked).
    task automatic conv(input int n, input int mode, input int exp_lat);
        int nvalid = 0;
        int ones = 0;
        int cycles = 0;
        int k = 0;
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int hold_n;
        len   = WIDTH'(n);
        start = 1'b1;
        step();
        cycles = 1;
        start  = 1'b0;
        len    = WIDTH'($urandom_range(0, 255));
        chk("busy_after_start", 32'(busy), 32'd1);
        while (nvalid < n) begin
            chk("no_early_valid", 32'(out_valid), 32'd0);
            case (mode)
                0: begin bit_valid = 1'b1; bit_in = 1'b1; end
                1: begin bit_valid = 1'b1; bit_in = (nvalid % 2 == 0); end
                2: begin bit_valid = ($urandom_range(0, 9) < 7); bit_in = $urandom_range(0, 1) == 1; end
                default: begin bit_valid = pat[k % 7]; bit_in = 1'b1; end
            endcase
            if (bit_valid) begin
                nvalid++;
                ones += int'(bit_in);
            end
            k++;
            step();
            cycles++;
            if (cycles > 3000) begin
                chk("accum_timeout", 32'(cycles), 32'd0);
                break;
            end
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        chk("out_valid_rise", 32'(out_valid), 32'd1);
        if (exp_lat != 0) chk("latency", 32'(cycles), 32'(exp_lat));
        chk("count", 32'(count), 32'(ones));
`ifdef SC_BIPOLAR_EN
        chk("value_bp", 32'(int'(value_bp)), 32'(2 * ones - n));
`endif
        // Backpressure with a stray start that must be ignored
        hold_n = $urandom_range(0, 4);
        for (int i = 0; i < hold_n; i++) begin
            start = (i == 0);
            bit_valid = 1'b1;
            bit_in = 1'b1;
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_count", 32'(count), 32'(ones));
            chk("hold_busy", 32'(busy), 32'd1);
        end
        bit_valid = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_count", 32'(count), 32'(ones));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        // bit_valid must be ignored in IDLE
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        step();
        bit_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_count", 32'(count), 32'd0);

        conv(16, 0, 17);
        conv(10, 1, 0);
        conv(4, 3, 8);
        conv(0, 0, 1);
        conv(8, 2, 0);

        // Reset in the middle of a long window
        len   = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        for (int i = 0; i < 50; i++) step();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bit_valid = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        conv(3, 0, 4);

        conv(255, 0, 256);
        for (int r = 0; r < 8; r++) conv($urandom_range(1, 40), 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_stream_counter.md
# sc_stream_counter

Stochastic-to-binary converter sitting directly downstream of the `lfsr`-based bitstream generators. It consumes a unipolar stochastic bitstream one bit per cycle, counts the ones over a programmable window of valid samples, and presents the binary estimate on a valid/ready output handshake. It closes the stochastic datapath so the results of stochastic arithmetic can be read back as binary values.

## Interface
- `WIDTH`, default 8: width of the window length, the sample counter and the result.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a new conversion; honoured only in IDLE.
- `len` in WIDTH: window length in valid samples; latched when `start` is accepted.
- `bit_in` in 1: stochastic bitstream input, e.g. `q` of an `lfsr`.
- `bit_valid` in 1: `bit_in` is a sample this cycle.
- `busy` out 1: high whenever state is not IDLE.
- `count` out WIDTH: number of ones in the window; stable while `out_valid` is high.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `value_bp` out WIDTH+1, signed: bipolar result. Present only with `SC_BIPOLAR_EN`.

## Operation
- **Registers**
  - `state`: IDLE, ACCUM or HOLD.
  - `len_r`: WIDTH bits.
  - `samples`: WIDTH bits.
  - `ones`: WIDTH bits; drives `count`.
- **Reset:** state IDLE; `len_r`, `samples`, `ones` = 0; `busy` = 0, `out_valid` = 0, `count` = 0; `value_bp` = 0 when present.
- **IDLE**
  - `start` = 1: latch `len_r` = `len`, clear `samples` and `ones`.
  - Next state is ACCUM, or HOLD if `len` = 0.
  - `bit_valid` is ignored in IDLE.
- **ACCUM**, on each cycle with `bit_valid` = 1:
  - `samples` += 1 and `ones` += `bit_in`.
  - If `samples` + 1 = `len_r`, next state is HOLD. `ones` includes that final bit.
  - Cycles with `bit_valid` = 0 change nothing.
  - `start` is ignored.
- **HOLD**
  - `out_valid` = 1; `count` = `ones`, held stable.
  - On `out_valid` && `out_ready`, next state is IDLE. `count` keeps its value until the next accepted `start` clears it.
  - `start` is ignored in HOLD, including the handshake cycle. Back-to-back conversions therefore have one IDLE cycle between them.
- **Arithmetic:** `ones` ≤ `samples` ≤ `len_r` ≤ 2^WIDTH−1, so no counter can overflow. No saturation logic is needed.
- **`rst` mid-conversion:** in any state, the next cycle is IDLE with all reset values. A partial result is discarded and never signalled.

## Timing
- `start` is accepted at cycle t. With `bit_valid` held high:
  - bits are sampled at cycles t+1 … t+len;
  - `out_valid` rises at t+len+1.
- **`len` = 0:** `out_valid` = 1 at t+1 with `count` = 0.
- **Output latency:** `out_valid` rises the cycle after the last valid sample; `count` is registered.
- **Handshake:** `out_valid` stays high until the cycle in which `out_ready` = 1. It is low the following cycle.
- `busy` rises at t+1 and falls the cycle after the handshake.

## Configuration
- **`SC_BIPOLAR_EN` defined:**
  - Adds the `value_bp` output, registered alongside `count`: `value_bp` = 2·`ones` − `len_r`, as a WIDTH+1-bit two's-complement value.
  - Valid whenever `out_valid` = 1; cleared by the same events as `count`.
- **`SC_BIPOLAR_EN` not defined:** the port and its logic are absent; unipolar `count` only.

## Test plan
1. Unipolar, all ones: WIDTH=8, `len`=16, `bit_in`=1, `bit_valid`=1 → `out_valid` rises 17 cycles after `start`, `count`=16, `busy` high throughout.
2. Alternating stream: `len`=10, `bit_in`=1,0,1,0,… → `count`=5; with `SC_BIPOLAR_EN`, `value_bp`=0.
3. Valid gaps: `len`=4, `bit_valid` pattern 1,0,0,1,1,0,1 with `bit_in`=1 on every valid cycle → `out_valid` the cycle after the 7th input cycle, `count`=4.
4. Zero window and backpressure:
   - `len`=0 → `out_valid` the cycle after `start`, `count`=0.
   - Then hold `out_ready`=0 for 5 cycles and pulse `start` → `count` stable, `start` ignored; `out_ready`=1 → IDLE next cycle.
5. Reset mid-conversion: `len`=200; assert `rst` after 50 samples → next cycle `busy`=0, `out_valid`=0, `count`=0. A fresh `start` with `len`=3 and all ones → `count`=3.
6. Bipolar extremes (`SC_BIPOLAR_EN`): `len`=8 with 2 ones → `value_bp`=−4. `len`=255 with all ones → `value_bp`=+255, `count`=255, no overflow.
